fcvt_wb: RTL and testbench
==========================

FCVT_WB -- requirements
Module: fcvt_wb

Interface
REQ-001 SHALL have parameter RD_W, 5, destination register index width.
REQ-002 SHALL have parameter RESET_FRM, 3'b000, frm value loaded at reset.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk input 1 (all state on rising edge), and rst input 1.
REQ-004 SHALL have ports: in_valid input 1 (converter result valid); in_ready output 1 (result accepted).
REQ-005 SHALL have ports: in_data input 32 (converted integer); in_rd input RD_W (destination index).
REQ-006 SHALL have port in_flags input 5 ({NV,DZ,OF,UF,NX}; converter invalid→NV, OF→OF, UF→UF, NX→NX, DZ from other FP units).
REQ-007 SHALL have ports: out_valid output 1; out_ready input 1; out_data output 32; out_rd output RD_W (writeback to integer register file).
REQ-008 SHALL have ports: csr_en input 1; csr_op input 2 (00 read, 01 write, 10 set, 11 clear); csr_addr input 12; csr_wdata input 32.
REQ-009 SHALL have ports: csr_rdata output 32; csr_err output 1 (unsupported address).
REQ-010 SHALL have ports: instr_rm input 3 (rm field of instruction); rm_out output 3 (resolved mode to converter frm); rm_illegal output 1.

Function
REQ-011 SHALL hold architectural state fflags[4:0] and frm[2:0].
REQ-012 SHALL resolve rounding mode combinationally: rm_out = (instr_rm==3'b111) ? frm : instr_rm.
REQ-013 SHALL assert rm_illegal when rm_out is 101, 110 or 111.
REQ-014 SHALL decode CSR addresses 0x001 fflags, 0x002 frm and 0x003 fcsr ({frm,fflags}).
REQ-015 SHALL drive csr_rdata zero-extended and combinational from pre-update state.
REQ-016 SHALL, on csr_en to any other address, give csr_rdata=0 and csr_err=1, with no state change.
REQ-017 SHALL compute the CSR new value as: write = wdata, set = old|wdata, clear = old&~wdata, read = old.
REQ-018 SHALL truncate the CSR new value to the field width and commit it at the next edge.
REQ-019 SHALL accept a result when in_valid&&in_ready.
REQ-020 SHALL OR in_flags of an accepted result into fflags at the same edge (sticky; only software clears).
REQ-021 SHALL apply both in order when a CSR write and an accepted result coincide: fflags_next = csr_new_fflags | in_flags, so no flag is lost.
REQ-022 SHALL present accepted data/rd on out_* one cycle after acceptance with out_valid=1.
REQ-023 SHALL hold out_* stable while out_valid&&!out_ready.
REQ-024 SHALL deliver results in acceptance order, with no drop and no duplicate.
REQ-025 SHALL allow simultaneous output drain and input accept for full throughput (one result per cycle).
REQ-026 SHALL keep in_ready independent of in_valid.

Reset
REQ-027 SHALL, on rst, set out_valid=0, out_data=0, out_rd=0, fflags=0 and frm=RESET_FRM.
REQ-028 SHALL, on rst, discard any buffered entry.
REQ-029 SHALL give rst priority over accept, drain and CSR write in the same cycle.
REQ-030 SHALL reflect reset state in csr_rdata and rm_out on the cycle after rst.

Configuration
REQ-031 SHALL, with FCVT_SKID_BUF_EN defined, add one skid entry, so in_ready is a register output (=!skid_valid).
REQ-032 SHALL, with FCVT_SKID_BUF_EN defined, capture an accept during output stall into the skid entry and move it to out_* on the next drain.
REQ-033 SHALL, with FCVT_SKID_BUF_EN undefined, have no skid entry and in_ready = !out_valid || out_ready (combinational).
REQ-034 SHALL keep flag accumulation and latency identical in both builds.

Structure
REQ-035 SHALL place in shared package fpu_pkg: fflags bit indices, CSR address constants, csr_op encodings and rounding-mode encodings (RNE, RTZ, RDN, RUP, RMM, DYN).
REQ-036 SHALL implement the output register plus optional skid entry as sub-module fcvt_skid.
REQ-037 SHALL keep CSR logic and rm resolve in fcvt_wb.

Verification
REQ-038 SHALL cover: results with in_flags 5'b00001 then 5'b10000 -> fflags=5'b10001; CSR read 0x001 returns 32'h11.
REQ-039 SHALL cover: csr write 0x003 with 32'hE5 -> frm=3'b111, fflags=5'b00101; instr_rm=111 -> rm_out=111, rm_illegal=1.
REQ-040 SHALL cover: CSR clear 0x001 with 32'h1F in same cycle as accepted result with in_flags=5'b00010 -> fflags=5'b00010.
REQ-041 SHALL cover: out_ready low 3 cycles during back-to-back inputs 32'hA, 32'hB, 32'hC.
REQ-042 SHALL, in that stall case, deliver A, B, C in order, hold out_data stable, and deassert in_ready per the build (skid: after 2 held; none: after 1).
REQ-043 SHALL cover: rst asserted while out_valid=1 and fflags=5'h1F -> next cycle out_valid=0, fflags=0, frm=RESET_FRM.
REQ-044 SHALL cover: csr_en to address 0x004 -> csr_err=1, csr_rdata=0, and fflags/frm unchanged.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: fflags bit positions, FP CSR addresses,
// CSR operation encodings and rounding-mode encodings.
package fpu_pkg;

    // Bit positions within fflags, matching the {NV,DZ,OF,UF,NX} layout
    localparam int FFLAG_NX = 0;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_NV = 4;

    localparam logic [11:0] CSR_FFLAGS = 12'h001;
    localparam logic [11:0] CSR_FRM    = 12'h002;
    localparam logic [11:0] CSR_FCSR   = 12'h003;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100,
        RM_DYN = 3'b111
    } rm_e;

    // Encodings 101/110 are reserved; 111 is only meaningful in the
    // instruction, so a resolved mode of 111 (frm holding DYN) is illegal.
    function automatic logic rm_is_illegal(input logic [2:0] rm);
        return rm inside {3'b101, 3'b110, 3'b111};
    endfunction

endpackage

// File: rtl/fcvt_skid.sv
// Writeback output register for converter results, with an optional
// second (skid) entry.
// Build option: FCVT_SKID_BUF_EN adds the skid entry; in_ready then comes
// straight from a flop. Without it, in_ready is combinational from out_ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_data/in_rd payload
//   out_valid/out_ready downstream handshake; out_data/out_rd payload
module fcvt_skid #(
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_data,
    input  logic [RD_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic [RD_W-1:0] out_rd
);

    logic accept;
    logic load;

    // Output register may take a new value when empty or being drained
    assign load   = !out_valid || out_ready;
    assign accept = in_valid && in_ready;

`ifdef FCVT_SKID_BUF_EN
    logic            skid_valid;
    logic [31:0]     skid_data;
    logic [RD_W-1:0] skid_rd;

    assign in_ready = !skid_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_rd     <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_rd    <= '0;
        end else if (load) begin
            // in_ready is low while the skid is full, so an accept and a
            // pending skid entry never compete for the output register
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                out_rd     <= skid_rd;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
                out_rd    <= in_rd;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
            skid_rd    <= in_rd;
        end
    end
`else
    assign in_ready = load;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_rd    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_rd    <= in_rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/fcvt_wb.sv
// FP-to-integer convert writeback: forwards converter results to the
// integer register file, accumulates exception flags into fflags, owns
// the fflags/frm/fcsr CSRs and resolves the dynamic rounding mode.
// Build option: FCVT_SKID_BUF_EN (see fcvt_skid) adds one skid entry.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready, in_data, in_rd, in_flags   converter result
//   out_valid/out_ready, out_data, out_rd         register-file writeback
//   csr_en, csr_op, csr_addr, csr_wdata, csr_rdata, csr_err   CSR access
//   instr_rm, rm_out, rm_illegal   rounding-mode resolve
module fcvt_wb
    import fpu_pkg::*;
#(
    parameter int          RD_W      = 5,
    parameter logic [2:0]  RESET_FRM = 3'b000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_data,
    input  logic [RD_W-1:0] in_rd,
    input  logic [4:0]      in_flags,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic [RD_W-1:0] out_rd,
    input  logic            csr_en,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [31:0]     csr_wdata,
    output logic [31:0]     csr_rdata,
    output logic            csr_err,
    input  logic [2:0]      instr_rm,
    output logic [2:0]      rm_out,
    output logic            rm_illegal
);

    logic [4:0] fflags;
    logic [2:0] frm;
    logic [4:0] fflags_next;
    logic [2:0] frm_next;
    logic       accept;
    logic       csr_hit;
    logic       wr_fflags;
    logic       wr_frm;
    logic [7:0] csr_old;
    logic [7:0] csr_new;

    assign accept = in_valid && in_ready;

    fcvt_skid #(.RD_W(RD_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd)
    );

    always_comb begin
        csr_hit = 1'b1;
        csr_old = '0;
        case (csr_addr)
            CSR_FFLAGS: csr_old = {3'b000, fflags};
            CSR_FRM:    csr_old = {5'b00000, frm};
            CSR_FCSR:   csr_old = {frm, fflags};
            default:    csr_hit = 1'b0;
        endcase

        case (csr_op_e'(csr_op))
            CSR_OP_WRITE: csr_new = csr_wdata[7:0];
            CSR_OP_SET:   csr_new = csr_old | csr_wdata[7:0];
            CSR_OP_CLEAR: csr_new = csr_old & ~csr_wdata[7:0];
            default:      csr_new = csr_old;
        endcase

        wr_fflags = csr_en && (csr_addr == CSR_FFLAGS || csr_addr == CSR_FCSR);
        wr_frm    = csr_en && (csr_addr == CSR_FRM || csr_addr == CSR_FCSR);

        // Software update first, then the hardware flags on top, so a
        // flag raised in the same cycle as a clear is never lost
        fflags_next = (wr_fflags ? csr_new[4:0] : fflags) | (accept ? in_flags : 5'b00000);

        frm_next = frm;
        if (wr_frm)
            frm_next = (csr_addr == CSR_FRM) ? csr_new[2:0] : csr_new[7:5];
    end

    assign csr_rdata  = {24'h000000, csr_old};
    assign csr_err    = csr_en && !csr_hit;
    assign rm_out     = (instr_rm == RM_DYN) ? frm : instr_rm;
    assign rm_illegal = rm_is_illegal(rm_out);

    always_ff @(posedge clk) begin
        if (rst) begin
            fflags <= '0;
            frm    <= RESET_FRM;
        end else begin
            fflags <= fflags_next;
            frm    <= frm_next;
        end
    end

endmodule

// File: tb/tb_fcvt_wb.sv
// Self-checking bench for fcvt_wb: directed scenarios followed by
// randomized traffic, checked every cycle against a queue-based model.
module tb_fcvt_wb;

    localparam int         RD_W   = 5;
    localparam logic [2:0] TB_RFRM = 3'b010;
`ifdef FCVT_SKID_BUF_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_data;
    logic [RD_W-1:0] in_rd;
    logic [4:0]      in_flags;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_data;
    logic [RD_W-1:0] out_rd;
    logic            csr_en;
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [31:0]     csr_wdata;
    logic [31:0]     csr_rdata;
    logic            csr_err;
    logic [2:0]      instr_rm;
    logic [2:0]      rm_out;
    logic            rm_illegal;

    always #5 clk = ~clk;

    fcvt_wb #(.RD_W(RD_W), .RESET_FRM(TB_RFRM)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_rd(in_rd), .in_flags(in_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd),
        .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_err(csr_err),
        .instr_rm(instr_rm), .rm_out(rm_out), .rm_illegal(rm_illegal)
    );

    typedef struct {
        logic [31:0]     data;
        logic [RD_W-1:0] rd;
    } ent_t;

    // Reference model: results in flight, architectural CSR state
    ent_t        q[$];
    logic [31:0] delivered[$];
    logic [4:0]  fflags_m;
    logic [2:0]  frm_m;
    bit          acc_m;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] csr_view(input logic [11:0] a);
        case (a)
            12'h001: return 32'(fflags_m);
            12'h002: return 32'(frm_m);
            12'h003: return 32'(frm_m) * 32 + 32'(fflags_m);
            default: return 32'h0;
        endcase
    endfunction

    task automatic idle();
        rst = 0; in_valid = 0; in_data = 0; in_rd = 0; in_flags = 0;
        out_ready = 1; csr_en = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
        instr_rm = 0;
    endtask

    // One clock: check every output against the model, then advance the model.
    task automatic cycle();
        bit          exp_ready, sup, drn;
        logic [31:0] old_v, new_v;
        logic [2:0]  rm_e;
        logic [4:0]  ff_n;
        logic [2:0]  frm_n;
        @(negedge clk);
        exp_ready = SKID ? (q.size() < 2) : (q.size() == 0 || out_ready);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check("out_data", out_data, q[0].data);
            check("out_rd", 32'(out_rd), 32'(q[0].rd));
            if (out_ready) delivered.push_back(out_data);
        end
        rm_e = (instr_rm == 3'd7) ? frm_m : instr_rm;
        check("rm_out", 32'(rm_out), 32'(rm_e));
        check("rm_illegal", 32'(rm_illegal), 32'(rm_e >= 3'd5));
        sup   = (csr_addr >= 12'd1 && csr_addr <= 12'd3);
        old_v = csr_view(csr_addr);
        check("csr_rdata", csr_rdata, old_v);
        check("csr_err", 32'(csr_err), 32'(csr_en && !sup));

        acc_m = 0;
        if (rst) begin
            q.delete();
            fflags_m = 0;
            frm_m    = TB_RFRM;
        end else begin
            acc_m = in_valid && exp_ready;
            drn   = (q.size() > 0) && out_ready;
            ff_n  = fflags_m;
            frm_n = frm_m;
            if (csr_en && sup) begin
                case (csr_op)
                    2'b01:   new_v = csr_wdata;
                    2'b10:   new_v = old_v | csr_wdata;
                    2'b11:   new_v = old_v & ~csr_wdata;
                    default: new_v = old_v;
                endcase
                if (csr_addr == 12'd1) ff_n = new_v[4:0];
                if (csr_addr == 12'd2) frm_n = new_v[2:0];
                if (csr_addr == 12'd3) begin
                    ff_n  = new_v[4:0];
                    frm_n = new_v[7:5];
                end
            end
            if (acc_m) ff_n = ff_n | in_flags;
            fflags_m = ff_n;
            frm_m    = frm_n;
            if (drn) void'(q.pop_front());
            if (acc_m) q.push_back('{in_data, in_rd});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic csr_peek(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_en = 1; csr_op = 2'b00; csr_addr = a;
        #1;
        check(tag, csr_rdata, exp);
        csr_en = 0;
    endtask

    logic [31:0] abc[3];
    int          idx, stall_acc;

    initial begin
        idle();
        rst = 1;
        cycle();
        cycle();
        rst = 0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_rd", 32'(out_rd), 32'h0);
        csr_peek("rst_fcsr", 12'h003, {24'h0, TB_RFRM, 5'b00000});
        instr_rm = 3'b111; #1;
        check("rst_rm_out", 32'(rm_out), 32'(TB_RFRM));
        instr_rm = 3'b000;

        // Two results with distinct flags accumulate
        in_valid = 1; in_data = 32'h1234; in_rd = 5'd3; in_flags = 5'b00001;
        cycle();
        in_data = 32'h5678; in_rd = 5'd4; in_flags = 5'b10000;
        cycle();
        idle();
        cycle();
        csr_peek("acc_fflags", 12'h001, 32'h11);

        // fcsr write splits into frm/fflags; dynamic rm picks up illegal frm
        csr_en = 1; csr_op = 2'b01; csr_addr = 12'h003; csr_wdata = 32'hE5;
        cycle();
        idle();
        csr_peek("wr_frm", 12'h002, 32'h7);
        csr_peek("wr_fflags", 12'h001, 32'h5);
        instr_rm = 3'b111; #1;
        check("dyn_rm_out", 32'(rm_out), 32'h7);
        check("dyn_rm_illegal", 32'(rm_illegal), 32'h1);
        instr_rm = 3'b000;

        // Clear all flags while a result raises one
        csr_en = 1; csr_op = 2'b11; csr_addr = 12'h001; csr_wdata = 32'h1F;
        in_valid = 1; in_data = 32'h99; in_rd = 5'd7; in_flags = 5'b00010;
        cycle();
        idle();
        cycle();
        csr_peek("clr_vs_flag", 12'h001, 32'h2);

        // Back-to-back A,B,C with the output stalled for three cycles
        abc[0] = 32'hA; abc[1] = 32'hB; abc[2] = 32'hC;
        delivered.delete();
        idx = 0; stall_acc = 0;
        for (int k = 0; k < 20 && idx < 3; k++) begin
            in_valid = 1; in_data = abc[idx]; in_rd = 5'(idx + 1); in_flags = 0;
            out_ready = (k >= 3);
            cycle();
            if (acc_m) begin
                idx++;
                if (k < 3) stall_acc++;
            end
        end
        idle();
        for (int k = 0; k < 10 && delivered.size() < 3; k++) cycle();
        check("stall_accepted", 32'(idx), 32'd3);
        check("stall_accepts_held", 32'(stall_acc), SKID ? 32'd2 : 32'd1);
        check("stall_count", 32'(delivered.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check("stall_order", (i < delivered.size()) ? delivered[i] : 32'hDEAD, abc[i]);

        // Reset with a pending output and all flags set
        csr_en = 1; csr_op = 2'b01; csr_addr = 12'h001; csr_wdata = 32'h1F;
        in_valid = 1; in_data = 32'h77; out_ready = 0;
        cycle();
        idle();
        out_ready = 0;
        #1;
        check("pre_rst_valid", 32'(out_valid), 32'h1);
        csr_peek("pre_rst_fflags", 12'h001, 32'h1F);
        rst = 1; in_valid = 1; csr_en = 1; csr_op = 2'b01; csr_addr = 12'h002; csr_wdata = 32'h4;
        cycle();
        idle();
        #1;
        check("post_rst_valid", 32'(out_valid), 32'h0);
        csr_peek("post_rst_fflags", 12'h001, 32'h0);
        csr_peek("post_rst_frm", 12'h002, 32'(TB_RFRM));

        // Unsupported address: error, zero data, no state change
        csr_en = 1; csr_op = 2'b01; csr_addr = 12'h004; csr_wdata = 32'hFF;
        #1;
        check("bad_err", 32'(csr_err), 32'h1);
        check("bad_rdata", csr_rdata, 32'h0);
        cycle();
        idle();
        csr_peek("bad_fcsr", 12'h003, {24'h0, TB_RFRM, 5'b00000});

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 59) == 0);
            in_valid  = $urandom_range(0, 1);
            in_data   = $urandom;
            in_rd     = 5'($urandom);
            in_flags  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
            out_ready = ($urandom_range(0, 9) < 6);
            csr_en    = ($urandom_range(0, 3) == 0);
            csr_op    = 2'($urandom);
            csr_addr  = 12'($urandom_range(0, 4));
            csr_wdata = $urandom;
            instr_rm  = 3'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
